// File: rtl/onchip_mem_pkg.sv
// Shared constants and configuration checks for the dual-port on-chip memory.
package onchip_mem_pkg;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic int NUM_LANES(input int w);
    return w / 8;
  endfunction

  // True when a parameter set describes a buildable memory.
  function automatic bit cfg_ok(input int lat, input int dw, input longint depth, input int aw);
    return (lat >= LAT_MIN) && (lat <= LAT_MAX) && (dw > 0) && ((dw % 8) == 0) &&
           (depth >= 1) && (depth <= (longint'(1) << aw));
  endfunction

endpackage

// File: rtl/onchip_mem_rdpipe.sv
// Per-port read response pipeline: valid/data shift register with clock-enable hold.
module onchip_mem_rdpipe
  import onchip_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_clken,
  input  logic                  i_vld,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_vld,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic                  r_vld_p1;
  logic                  w_vld_last;
  logic [DATA_WIDTH-1:0] w_data_last;
  logic [DATA_WIDTH-1:0] r_hold;

  // Stage 1: RAM output (data arrives already merged from the top level)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_vld_p1 <= 1'b0;
    else if (i_clken) r_vld_p1 <= i_vld;
  end

  if (READ_LATENCY == LAT_MAX) begin : g_stage2
    logic                  r_vld_p2;
    logic [DATA_WIDTH-1:0] r_data_p2;

    // Stage 2: pure register
    always_ff @(posedge clk or posedge reset) begin
      if (reset)        r_vld_p2 <= 1'b0;
      else if (i_clken) r_vld_p2 <= r_vld_p1;
    end

    always_ff @(posedge clk) begin
      if (i_clken) r_data_p2 <= i_data;
    end

    assign w_vld_last  = r_vld_p2;
    assign w_data_last = r_data_p2;
  end else begin : g_stage1
    assign w_vld_last  = r_vld_p1;
    assign w_data_last = i_data;
  end

  // Output: last delivered word is kept so readdata is stable between responses
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_hold <= '0;
    else if (i_clken && w_vld_last)  r_hold <= w_data_last;
  end

  assign o_vld  = w_vld_last & i_clken;
  assign o_data = w_vld_last ? w_data_last : r_hold;

endmodule

// File: rtl/onchip_mem_2port.sv
// True dual-port Avalon-MM on-chip RAM with pipelined reads, cross-port write-first
// forwarding and s1-priority write collision arbitration.
module onchip_mem_2port
  import onchip_mem_pkg::*;
#(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 16,
  parameter int    DEPTH        = 65536,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = "SoC_onchip_mem.hex"
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic                    s1_waitrequest,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic                    s2_waitrequest,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid
);

  localparam int                  NL      = NUM_LANES(DATA_WIDTH);
  localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

  if (!cfg_ok(READ_LATENCY, DATA_WIDTH, DEPTH, ADDR_WIDTH)) begin : g_cfg_err
    $error("onchip_mem_2port: illegal READ_LATENCY, DATA_WIDTH or DEPTH");
  end

  function automatic logic [DATA_WIDTH-1:0] fwd_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                      input logic [DATA_WIDTH-1:0] new_w,
                                                      input logic [NL-1:0]         be);
    logic [DATA_WIDTH-1:0] m;
    m = old_w;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) m[8*i +: 8] = new_w[8*i +: 8];
    end
    return m;
  endfunction

  logic                  w_req1, w_req2, w_wr1, w_wr2, w_rd1, w_rd2;
  logic                  w_inr1, w_inr2, w_coll, w_we1, w_we2;
  logic [IDX_W-1:0]      w_idx1, w_idx2;
  logic [DATA_WIDTH-1:0] w_d1, w_d2;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
  logic [DATA_WIDTH-1:0] r_q1, r_q2, r_fwd_d1, r_fwd_d2;
  logic [NL-1:0]         r_fwd_be1, r_fwd_be2;
  logic                  r_oor1, r_oor2;

  assign w_req1 = s1_chipselect & (s1_read | s1_write);
  assign w_req2 = s2_chipselect & (s2_read | s2_write);
  assign w_wr1  = s1_chipselect & s1_write;
  assign w_wr2  = s2_chipselect & s2_write;
  assign w_rd1  = s1_chipselect & s1_read & ~s1_write;
  assign w_rd2  = s2_chipselect & s2_read & ~s2_write;
  assign w_inr1 = {1'b0, s1_address} < DEPTH_C;
  assign w_inr2 = {1'b0, s2_address} < DEPTH_C;
  assign w_idx1 = s1_address[IDX_W-1:0];
  assign w_idx2 = s2_address[IDX_W-1:0];

  // The address compare is the only request-to-waitrequest path besides clken.
  assign w_coll         = w_wr1 & w_wr2 & (s1_address == s2_address);
  assign s1_waitrequest = w_req1 & ~clken;
  assign s2_waitrequest = w_req2 & (~clken | w_coll);

  assign w_we1 = clken & w_wr1 & w_inr1;
  assign w_we2 = clken & w_wr2 & w_inr2 & ~w_coll;

  // Array access: per-lane writes, registered reads, forwarding side-band captured alongside
  always_ff @(posedge clk) begin
    if (clken) begin
      for (int i = 0; i < NL; i++) begin
        if (w_we1 && s1_byteenable[i]) r_mem[w_idx1][8*i +: 8] <= s1_writedata[8*i +: 8];
        if (w_we2 && s2_byteenable[i]) r_mem[w_idx2][8*i +: 8] <= s2_writedata[8*i +: 8];
      end
      r_q1      <= r_mem[w_idx1];
      r_q2      <= r_mem[w_idx2];
      r_fwd_be1 <= (w_we2 && (s2_address == s1_address)) ? s2_byteenable : '0;
      r_fwd_be2 <= (w_we1 && (s1_address == s2_address)) ? s1_byteenable : '0;
      r_fwd_d1  <= s2_writedata;
      r_fwd_d2  <= s1_writedata;
      r_oor1    <= ~w_inr1;
      r_oor2    <= ~w_inr2;
    end
  end

  assign w_d1 = r_oor1 ? '0 : fwd_merge(r_q1, r_fwd_d1, r_fwd_be1);
  assign w_d2 = r_oor2 ? '0 : fwd_merge(r_q2, r_fwd_d2, r_fwd_be2);

  onchip_mem_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_rdpipe_s1 (
    .clk     (clk),
    .reset   (reset),
    .i_clken (clken),
    .i_vld   (clken & w_rd1),
    .i_data  (w_d1),
    .o_vld   (s1_readdatavalid),
    .o_data  (s1_readdata)
  );

  onchip_mem_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .READ_LATENCY(READ_LATENCY)) u_rdpipe_s2 (
    .clk     (clk),
    .reset   (reset),
    .i_clken (clken),
    .i_vld   (clken & w_rd2),
    .i_data  (w_d2),
    .o_vld   (s2_readdatavalid),
    .o_data  (s2_readdata)
  );

endmodule

// File: tb/tb_onchip_mem_2port.sv
// Scoreboard bench for onchip_mem_2port: directed scenarios plus randomized dual-port traffic.
module tb_onchip_mem_2port;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int DEP = 1000;
  localparam int LAT = 2;
  localparam int NB  = DW / 8;

  typedef struct {
    logic          cs, rd, wr;
    logic [AW-1:0] a;
    logic [NB-1:0] be;
    logic [DW-1:0] wd;
  } req_t;

  typedef struct {
    logic [DW-1:0] d;
    int            due;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          clken = 1'b1;
  logic [AW-1:0] s1_address, s2_address;
  logic [NB-1:0] s1_byteenable, s2_byteenable;
  logic          s1_chipselect, s1_read, s1_write, s2_chipselect, s2_read, s2_write;
  logic [DW-1:0] s1_writedata, s2_writedata, s1_readdata, s2_readdata;
  logic          s1_waitrequest, s2_waitrequest, s1_readdatavalid, s2_readdatavalid;

  int            checks = 0;
  int            errors = 0;
  int            en_cnt = 0;
  exp_t          q1[$];
  exp_t          q2[$];
  exp_t          e;
  logic          exp_w1, exp_w2;
  logic [DW-1:0] mdl [0:DEP-1];

  onchip_mem_2port #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP), .READ_LATENCY(LAT), .INIT_FILE("")
  ) dut (
    .clk(clk), .reset(reset), .clken(clken),
    .s1_address(s1_address), .s1_byteenable(s1_byteenable), .s1_chipselect(s1_chipselect),
    .s1_read(s1_read), .s1_write(s1_write), .s1_writedata(s1_writedata),
    .s1_waitrequest(s1_waitrequest), .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .s2_address(s2_address), .s2_byteenable(s2_byteenable), .s2_chipselect(s2_chipselect),
    .s2_read(s2_read), .s2_write(s2_write), .s2_writedata(s2_writedata),
    .s2_waitrequest(s2_waitrequest), .s2_readdata(s2_readdata), .s2_readdatavalid(s2_readdatavalid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (clken) en_cnt <= en_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic req_t idle_req();
    req_t r;
    r.cs = 1'b0; r.rd = 1'b0; r.wr = 1'b0; r.a = '0; r.be = '0; r.wd = '0;
    return r;
  endfunction

  function automatic req_t rd_req(input int a);
    req_t r;
    r = idle_req(); r.cs = 1'b1; r.rd = 1'b1; r.a = AW'(a);
    return r;
  endfunction

  function automatic req_t wr_req(input int a, input logic [NB-1:0] be, input logic [DW-1:0] wd);
    req_t r;
    r = idle_req(); r.cs = 1'b1; r.wr = 1'b1; r.a = AW'(a); r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   op;
    r    = idle_req();
    r.cs = ($urandom_range(0, 9) < 8);
    op   = int'($urandom_range(0, 9));
    r.rd = (op < 5) || (op == 9);
    r.wr = (op >= 5);
    r.a  = ($urandom_range(0, 19) == 0) ? AW'($urandom_range(DEP, 1023)) : AW'($urandom_range(0, 15));
    r.be = NB'($urandom);
    r.wd = $urandom;
    return r;
  endfunction

  // Reference memory: a write touches only enabled lanes of an in-range word.
  function automatic void mdl_write(input req_t r);
    if (int'(r.a) < DEP)
      for (int i = 0; i < NB; i++)
        if (r.be[i]) mdl[r.a][8*i +: 8] = r.wd[8*i +: 8];
  endfunction

  function automatic logic [DW-1:0] mdl_read(input logic [AW-1:0] a);
    return (int'(a) < DEP) ? mdl[a] : '0;
  endfunction

  function automatic logic [DW-1:0] fill_val(input int a);
    if (a == 5 || a == 16) return 32'hDEADBEEF;
    if (a == 48)           return 32'h0;
    return $urandom;
  endfunction

  task automatic apply(input req_t r1, input req_t r2);
    s1_chipselect = r1.cs; s1_read = r1.rd; s1_write = r1.wr;
    s1_address = r1.a; s1_byteenable = r1.be; s1_writedata = r1.wd;
    s2_chipselect = r2.cs; s2_read = r2.rd; s2_write = r2.wr;
    s2_address = r2.a; s2_byteenable = r2.be; s2_writedata = r2.wd;
  endtask

  // Present one cycle of requests; acceptance follows the DUT's waitrequest like a real master.
  // Same-cycle writes are applied to the model before reads are evaluated (write-first).
  task automatic do_cycle(input logic ce, input req_t r1, input req_t r2,
                          output logic acc1, output logic acc2);
    @(posedge clk);
    #1;
    clken = ce;
    apply(r1, r2);
    @(negedge clk);
    acc1 = ce & r1.cs & (r1.rd | r1.wr) & ~s1_waitrequest;
    acc2 = ce & r2.cs & (r2.rd | r2.wr) & ~s2_waitrequest;
    if (acc1 && r1.wr) mdl_write(r1);
    if (acc2 && r2.wr) mdl_write(r2);
    if (acc1 && r1.rd && !r1.wr) q1.push_back('{d: mdl_read(r1.a), due: en_cnt + LAT});
    if (acc2 && r2.rd && !r2.wr) q2.push_back('{d: mdl_read(r2.a), due: en_cnt + LAT});
  endtask

  task automatic cyc(input logic ce, input req_t r1, input req_t r2);
    logic a1, a2;
    do_cycle(ce, r1, r2, a1, a2);
  endtask

  // Monitor: checks waitrequest rules, stall behaviour, reset state and pops responses.
  always @(negedge clk) begin
    if (reset) begin
      checks++;
      if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0 ||
          s1_readdata !== '0 || s2_readdata !== '0) begin
        errors++;
        $display("FAIL reset_state rdv1=%b rd1=%h rdv2=%b rd2=%h required all zero",
                 s1_readdatavalid, s1_readdata, s2_readdatavalid, s2_readdata);
      end
    end else begin
      exp_w1 = s1_chipselect & (s1_read | s1_write) & ~clken;
      exp_w2 = s2_chipselect & (s2_read | s2_write) &
               (~clken | (s1_chipselect & s1_write & s2_chipselect & s2_write &
                          (s1_address == s2_address)));
      checks++;
      if (s1_waitrequest !== exp_w1 || s2_waitrequest !== exp_w2) begin
        errors++;
        $display("FAIL waitrequest t=%0t got s1=%b s2=%b required s1=%b s2=%b",
                 $time, s1_waitrequest, s2_waitrequest, exp_w1, exp_w2);
      end
      if (!clken) begin
        checks++;
        if (s1_readdatavalid !== 1'b0 || s2_readdatavalid !== 1'b0) begin
          errors++;
          $display("FAIL rdv_during_stall got s1=%b s2=%b required 0 0",
                   s1_readdatavalid, s2_readdatavalid);
        end
      end else begin
        if (s1_readdatavalid) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL s1_unexpected_rdv data=%h required no response", s1_readdata);
          end else begin
            e = q1.pop_front();
            if (s1_readdata !== e.d || en_cnt != e.due) begin
              errors++;
              $display("FAIL s1_read got data=%h cycle=%0d required data=%h cycle=%0d",
                       s1_readdata, en_cnt, e.d, e.due);
            end
          end
        end else if (q1.size() != 0 && q1[0].due <= en_cnt) begin
          checks++; errors++;
          $display("FAIL s1_missing_rdv got none at cycle=%0d required data=%h at cycle=%0d",
                   en_cnt, q1[0].d, q1[0].due);
          void'(q1.pop_front());
        end
        if (s2_readdatavalid) begin
          checks++;
          if (q2.size() == 0) begin
            errors++;
            $display("FAIL s2_unexpected_rdv data=%h required no response", s2_readdata);
          end else begin
            e = q2.pop_front();
            if (s2_readdata !== e.d || en_cnt != e.due) begin
              errors++;
              $display("FAIL s2_read got data=%h cycle=%0d required data=%h cycle=%0d",
                       s2_readdata, en_cnt, e.d, e.due);
            end
          end
        end else if (q2.size() != 0 && q2[0].due <= en_cnt) begin
          checks++; errors++;
          $display("FAIL s2_missing_rdv got none at cycle=%0d required data=%h at cycle=%0d",
                   en_cnt, q2[0].d, q2[0].due);
          void'(q2.pop_front());
        end
      end
    end
  end

  initial begin
    logic a1, a2;
    int   n;
    apply(idle_req(), idle_req());
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Known contents for the low 64 words, both ports writing in parallel.
    for (int k = 0; k < 32; k++)
      cyc(1'b1, wr_req(2*k, '1, fill_val(2*k)), wr_req(2*k + 1, '1, fill_val(2*k + 1)));

    cyc(1'b1, rd_req(5), idle_req());

    cyc(1'b1, wr_req(16, 4'b0101, 32'h11223344), idle_req());
    cyc(1'b1, idle_req(), rd_req(16));

    do_cycle(1'b1, wr_req(32, '1, 32'hAAAAAAAA), wr_req(32, '1, 32'h55555555), a1, a2);
    for (int t = 0; t < 4 && !a2; t++)
      do_cycle(1'b1, idle_req(), wr_req(32, '1, 32'h55555555), a1, a2);
    cyc(1'b1, rd_req(32), idle_req());

    cyc(1'b1, wr_req(48, 4'b0011, 32'hCAFEF00D), rd_req(48));

    n = 0;
    for (int c = 0; c < 20 && n < 4; c++) begin
      do_cycle(!(c >= 2 && c < 5), rd_req(n), idle_req(), a1, a2);
      if (a1) n++;
    end

    cyc(1'b1, wr_req(DEP, '1, $urandom), idle_req());
    cyc(1'b1, rd_req(DEP), rd_req(1023));

    for (int k = 0; k < 400; k++)
      cyc($urandom_range(0, 9) != 0, rand_req(), rand_req());
    repeat (8) cyc(1'b1, idle_req(), idle_req());

    // Reset in the cycle after a read is accepted: the response must never appear.
    do_cycle(1'b1, rd_req(7), idle_req(), a1, a2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    apply(idle_req(), idle_req());
    q1.delete();
    q2.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (6) cyc(1'b1, idle_req(), idle_req());
    cyc(1'b1, rd_req(7), rd_req(16));

    repeat (10) cyc(1'b1, idle_req(), idle_req());
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
